// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives a single-outstanding
// req/addr_ok/data_ok SRAM handshake and offers fetched instructions to ID.
module fetch_ctrl #(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h1c000000)
) (
   input  logic            clk,
   input  logic            resetn,
   output logic            inst_sram_req,
   output logic [PC_W-1:0] inst_sram_addr,
   input  logic            inst_sram_addr_ok,
   input  logic            inst_sram_data_ok,
   input  logic [31:0]     inst_sram_rdata,
   input  logic            ex_flush,
   input  logic [PC_W-1:0] ex_entry,
   input  logic            ertn_flush,
   input  logic [PC_W-1:0] era,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            ds_allow_in,
   output logic            fs_to_ds_valid,
   output logic [PC_W-1:0] fs_pc,
   output logic [31:0]     fs_inst,
   output logic            fs_ex_adef
);

   typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_ADEF} state_t;

   state_t          state_reg, state_next;
   logic [PC_W-1:0] pc_reg, pc_next;
   logic            discard_reg, discard_next;
   logic [PC_W-1:0] pending_reg, pending_next;
   logic [31:0]     inst_buf_reg, inst_buf_next;

   logic            redirect;
   logic [PC_W-1:0] new_pc;
   logic [PC_W-1:0] pc_inc;
   logic            fire;
   logic            go_req;

   always_comb begin
      redirect = ex_flush | ertn_flush | br_taken;
      if (ex_flush)
         new_pc = ex_entry;
      else if (ertn_flush)
         new_pc = era;
      else
         new_pc = br_target;
   end

   assign pc_inc = pc_reg + PC_W'(4);

   always_comb begin
      fs_to_ds_valid = 1'b0;
      fs_inst        = 32'h0;
      case (state_reg)
         S_WAIT: begin
            fs_to_ds_valid = inst_sram_data_ok && !discard_reg && !redirect;
            fs_inst        = inst_sram_rdata;
         end
         S_HOLD: begin
            fs_to_ds_valid = !redirect;
            fs_inst        = inst_buf_reg;
         end
         S_ADEF:  fs_to_ds_valid = !redirect;
         default: ;
      endcase
   end

   assign fire           = fs_to_ds_valid && ds_allow_in;
   assign inst_sram_req  = (state_reg == S_REQ);
   assign inst_sram_addr = (state_reg == S_REQ) ? pc_reg : '0;
   assign fs_pc          = pc_reg;
   assign fs_ex_adef     = (state_reg == S_ADEF);

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      discard_next  = discard_reg;
      pending_next  = pending_reg;
      inst_buf_next = inst_buf_reg;
      go_req        = 1'b0;
      case (state_reg)
         S_BOOT: begin
            go_req = 1'b1;
            if (redirect)
               pc_next = new_pc;
         end
         S_REQ: begin
            if (inst_sram_addr_ok) begin
               // The request is already accepted, so its data must still be drained.
               state_next = S_WAIT;
               if (redirect) begin
                  discard_next = 1'b1;
                  pending_next = new_pc;
               end
            end else if (redirect) begin
               pc_next = new_pc;
               go_req  = 1'b1;
            end
         end
         S_WAIT: begin
            if (inst_sram_data_ok) begin
               if (discard_reg) begin
                  discard_next = 1'b0;
                  pc_next      = redirect ? new_pc : pending_reg;
                  go_req       = 1'b1;
               end else if (redirect) begin
                  pc_next = new_pc;
                  go_req  = 1'b1;
               end else if (fire) begin
                  pc_next = pc_inc;
                  go_req  = 1'b1;
               end else begin
                  inst_buf_next = inst_sram_rdata;
                  state_next    = S_HOLD;
               end
            end else if (redirect) begin
               discard_next = 1'b1;
               pending_next = new_pc;
            end
         end
         S_HOLD, S_ADEF: begin
            if (redirect) begin
               pc_next = new_pc;
               go_req  = 1'b1;
            end else if (fire) begin
               pc_next = pc_inc;
               go_req  = 1'b1;
            end
         end
         default: state_next = S_BOOT;
      endcase
      // A misaligned target never reaches the SRAM; it is offered as an ADEF slot.
      if (go_req)
         state_next = (pc_next[1:0] != 2'b00) ? S_ADEF : S_REQ;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= S_BOOT;
         pc_reg       <= RESET_PC;
         discard_reg  <= 1'b0;
         pending_reg  <= '0;
         inst_buf_reg <= 32'h0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         discard_reg  <= discard_next;
         pending_reg  <= pending_next;
         inst_buf_reg <= inst_buf_next;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios push expected requests and
// slots; a negedge monitor pops and compares on every SRAM grant and ID transfer.
module tb_fetch_ctrl;
   localparam logic [31:0] RESET_PC = 32'h1c000000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adef;
   } slot_t;

   logic        clk;
   logic        resetn;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        ex_flush;
   logic [31:0] ex_entry;
   logic        ertn_flush;
   logic [31:0] era;
   logic        br_taken;
   logic [31:0] br_target;
   logic        ds_allow_in;
   logic        fs_to_ds_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        fs_ex_adef;

   fetch_ctrl #(.PC_W(32), .RESET_PC(RESET_PC)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .inst_sram_req    (inst_sram_req),
      .inst_sram_addr   (inst_sram_addr),
      .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata  (inst_sram_rdata),
      .ex_flush         (ex_flush),
      .ex_entry         (ex_entry),
      .ertn_flush       (ertn_flush),
      .era              (era),
      .br_taken         (br_taken),
      .br_target        (br_target),
      .ds_allow_in      (ds_allow_in),
      .fs_to_ds_valid   (fs_to_ds_valid),
      .fs_pc            (fs_pc),
      .fs_inst          (fs_inst),
      .fs_ex_adef       (fs_ex_adef)
   );

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] addr_q[$];
   slot_t       slot_q[$];
   int          addr_cnt    = 0;
   int          fire_cnt    = 0;
   int          grant_limit = 0;
   int          data_dly    = 0;
   logic        took_addr   = 1'b0;
   logic        took_data   = 1'b0;
   logic        req_seen    = 1'b0;
   logic [31:0] took_addr_val = 32'h0;
   logic        force_data_ok = 1'b0;
   logic [31:0] force_rdata   = 32'h0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_addr(input logic [31:0] a);
      addr_q.push_back(a);
   endtask

   task automatic push_slot(input logic [31:0] pc, input logic [31:0] inst, input logic adef);
      slot_t s;
      s.pc = pc; s.inst = inst; s.adef = adef;
      slot_q.push_back(s);
   endtask

   // Monitor: records handshakes for the SRAM model and checks against the scoreboard.
   initial begin : monitor
      slot_t       s;
      logic [31:0] a;
      forever begin
         @(negedge clk);
         took_addr     = resetn && inst_sram_req && inst_sram_addr_ok;
         took_addr_val = inst_sram_addr;
         took_data     = inst_sram_data_ok;
         req_seen      = resetn && inst_sram_req;
         if (took_addr) begin
            addr_cnt++;
            $display("req  addr=%h", inst_sram_addr);
            if (addr_q.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL req_addr: unexpected request to %h, none expected", inst_sram_addr);
            end else begin
               a = addr_q.pop_front();
               check("req_addr", inst_sram_addr, a);
            end
         end
         if (fs_to_ds_valid && ds_allow_in) begin
            fire_cnt++;
            $display("slot pc=%h inst=%h adef=%b", fs_pc, fs_inst, fs_ex_adef);
            if (slot_q.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL slot: unexpected slot pc=%h, none expected", fs_pc);
            end else begin
               s = slot_q.pop_front();
               check("slot_pc", fs_pc, s.pc);
               check("slot_inst", fs_inst, s.inst);
               check("slot_adef", 32'(fs_ex_adef), 32'(s.adef));
            end
         end
      end
   end

   // SRAM model: addr_ok one cycle after req is first seen, data_dly cycles to data_ok.
   initial begin : sram
      logic        outstanding;
      logic [31:0] out_addr;
      int          wcnt;
      outstanding = 1'b0; out_addr = 32'h0; wcnt = 0;
      inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
      forever begin
         @(posedge clk); #2;
         if (!resetn) begin
            outstanding = 1'b0;
         end else begin
            if (took_data) outstanding = 1'b0;
            if (took_addr) begin
               outstanding = 1'b1; out_addr = took_addr_val; wcnt = 0;
            end
         end
         inst_sram_addr_ok = resetn && inst_sram_req && req_seen && (addr_cnt < grant_limit) && !outstanding;
         inst_sram_data_ok = force_data_ok || (outstanding && wcnt == data_dly);
         inst_sram_rdata   = force_data_ok ? force_rdata : (outstanding ? ~out_addr : 32'h0);
         if (outstanding) wcnt++;
      end
   end

   task automatic timeout(input string name, input int act, input int req);
      compared++; mismatched++;
      $display("FAIL %s: timeout, got %0d, expected %0d", name, act, req);
   endtask

   task automatic wait_addr(input int n);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (addr_cnt >= n) return;
      end
      timeout("wait_addr", addr_cnt, n);
   endtask

   task automatic wait_fire(input int n);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (fire_cnt >= n) return;
      end
      timeout("wait_fire", fire_cnt, n);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (fs_to_ds_valid) return;
      end
      timeout("wait_valid", 0, 1);
   endtask

   task automatic wait_req();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (inst_sram_req) return;
      end
      timeout("wait_req", 0, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (addr_q.size() == 0 && slot_q.size() == 0) break;
      end
      compared++;
      if (addr_q.size() != 0 || slot_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d requests and %0d slots outstanding, expected 0", addr_q.size(), slot_q.size());
         addr_q.delete();
         slot_q.delete();
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic clear_inputs();
      ex_flush = 1'b0; ex_entry = 32'h0; ertn_flush = 1'b0; era = 32'h0;
      br_taken = 1'b0; br_target = 32'h0; ds_allow_in = 1'b1;
      force_data_ok = 1'b0; force_rdata = 32'h0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"}, 32'(inst_sram_req), 32'h0);
      check({tag, "_addr"}, inst_sram_addr, 32'h0);
      check({tag, "_valid"}, 32'(fs_to_ds_valid), 32'h0);
      check({tag, "_pc"}, fs_pc, RESET_PC);
      check({tag, "_inst"}, fs_inst, 32'h0);
      check({tag, "_adef"}, 32'(fs_ex_adef), 32'h0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      resetn = 1'b0;
      clear_inputs();
      data_dly = 0;
      grant_limit = addr_cnt;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   initial begin : stim
      int a0;
      int f0;
      resetn = 1'b0;
      clear_inputs();
      @(negedge clk); #1;
      check_reset_outputs("rst0");

      // Streaming fetch with ID always ready
      push_addr(32'h1c000000); push_addr(32'h1c000004); push_addr(32'h1c000008);
      push_slot(32'h1c000000, 32'he3ffffff, 1'b0);
      push_slot(32'h1c000004, 32'he3fffffb, 1'b0);
      push_slot(32'h1c000008, 32'he3fffff7, 1'b0);
      grant_limit = addr_cnt + 3;
      @(posedge clk); #1 resetn = 1'b1;
      wait_idle();

      // ID stall: second instruction is held for three cycles
      do_reset();
      push_addr(32'h1c000000); push_addr(32'h1c000004); push_addr(32'h1c000008);
      push_slot(32'h1c000000, 32'he3ffffff, 1'b0);
      push_slot(32'h1c000004, 32'he3fffffb, 1'b0);
      push_slot(32'h1c000008, 32'he3fffff7, 1'b0);
      grant_limit = addr_cnt + 3;
      f0 = fire_cnt;
      wait_fire(f0 + 1);
      @(posedge clk); #1 ds_allow_in = 1'b0;
      wait_valid();
      for (int i = 0; i < 3; i++) begin
         check("hold_valid", 32'(fs_to_ds_valid), 32'h1);
         check("hold_inst", fs_inst, 32'he3fffffb);
         check("hold_pc", fs_pc, 32'h1c000004);
         check("hold_req", 32'(inst_sram_req), 32'h0);
         if (i < 2) begin @(negedge clk); #1; end
      end
      @(posedge clk); #1 ds_allow_in = 1'b1;
      wait_idle();

      // Branch coincident with data_ok drops the returning instruction
      do_reset();
      push_addr(32'h1c000000); push_addr(32'h1c000004); push_addr(32'h1c000008); push_addr(32'h1c000100);
      push_slot(32'h1c000000, 32'he3ffffff, 1'b0);
      push_slot(32'h1c000004, 32'he3fffffb, 1'b0);
      push_slot(32'h1c000100, 32'he3fffeff, 1'b0);
      a0 = addr_cnt;
      grant_limit = a0 + 4;
      wait_addr(a0 + 3);
      @(posedge clk); #1 br_taken = 1'b1; br_target = 32'h1c000100;
      @(negedge clk); #1 check("br_drop_valid", 32'(fs_to_ds_valid), 32'h0);
      @(posedge clk); #1 br_taken = 1'b0;
      wait_idle();

      // Redirects while waiting for slow data: discard, later redirect overrides target
      do_reset();
      data_dly = 2;
      push_addr(32'h1c000000); push_addr(32'h1c000400);
      push_slot(32'h1c000400, 32'he3fffbff, 1'b0);
      a0 = addr_cnt;
      grant_limit = a0 + 2;
      wait_addr(a0 + 1);
      @(posedge clk); #1 br_taken = 1'b1; br_target = 32'h1c000200;
      @(negedge clk); #1 check("disc_valid0", 32'(fs_to_ds_valid), 32'h0);
      @(posedge clk); #1 br_taken = 1'b0; ex_flush = 1'b1; ex_entry = 32'h1c000400;
      @(negedge clk); #1 check("disc_valid1", 32'(fs_to_ds_valid), 32'h0);
      @(posedge clk); #1 ex_flush = 1'b0;
      wait_idle();

      // ex_flush beats br_taken while the request is pending
      do_reset();
      wait_req();
      @(posedge clk); #1;
      ex_flush = 1'b1; ex_entry = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000100;
      @(posedge clk); #1;
      ex_flush = 1'b0; br_taken = 1'b0;
      push_addr(32'h1c008000);
      push_slot(32'h1c008000, 32'he3ff7fff, 1'b0);
      grant_limit = addr_cnt + 1;
      wait_idle();

      // ertn to a misaligned address: ADEF slot, no SRAM request
      do_reset();
      wait_req();
      @(posedge clk); #1;
      ertn_flush = 1'b1; era = 32'h1c000102; ds_allow_in = 1'b0;
      @(posedge clk); #1 ertn_flush = 1'b0;
      @(negedge clk); #1;
      check("adef_req", 32'(inst_sram_req), 32'h0);
      check("adef_valid", 32'(fs_to_ds_valid), 32'h1);
      check("adef_flag", 32'(fs_ex_adef), 32'h1);
      check("adef_pc", fs_pc, 32'h1c000102);
      check("adef_inst", fs_inst, 32'h0);
      push_slot(32'h1c000102, 32'h0, 1'b1);
      @(posedge clk); #1 ds_allow_in = 1'b1;
      @(posedge clk); #1;
      br_taken = 1'b1; br_target = 32'h1c000300;
      push_addr(32'h1c000300);
      push_slot(32'h1c000300, 32'he3fffcff, 1'b0);
      grant_limit = addr_cnt + 1;
      @(negedge clk); #1;
      check("adef_br_valid", 32'(fs_to_ds_valid), 32'h0);
      check("adef_next_pc", fs_pc, 32'h1c000106);
      @(posedge clk); #1 br_taken = 1'b0;
      wait_idle();

      // Reset while waiting for data, then a stray data_ok during BOOT
      do_reset();
      push_addr(32'h1c000000);
      a0 = addr_cnt;
      grant_limit = a0 + 1;
      wait_addr(a0 + 1);
      @(posedge clk); #1 resetn = 1'b0;
      @(negedge clk); #1 check_reset_outputs("rst_mid");
      @(posedge clk); #1;
      push_addr(32'h1c000000);
      push_slot(32'h1c000000, 32'he3ffffff, 1'b0);
      grant_limit = addr_cnt + 1;
      force_data_ok = 1'b1; force_rdata = 32'h12345678;
      resetn = 1'b1;
      @(negedge clk); #1;
      check("boot_valid", 32'(fs_to_ds_valid), 32'h0);
      check("boot_inst", fs_inst, 32'h0);
      @(posedge clk); #1 force_data_ok = 1'b0;
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
